fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 26 ++
 rtl/fetch_fifo.sv | 58 +++++
 rtl/fetch_unit.sv | 112 +++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : fetch_unit_pkg
// Description : Shared types and constants for the instruction fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

   localparam int FETCH_DEPTH_DEFAULT = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DROP = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : fetch_fifo
// Description : Instruction queue with synchronous flush; storage is not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
   import fetch_unit_pkg::*;
#(
   parameter int DEPTH = FETCH_DEPTH_DEFAULT
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [FETCH_ENTRY_W-1:0] wdata,
   input  logic                     pop,
   input  logic                     flush,
   output logic                     full,
   output logic                     empty,
   output logic [FETCH_ENTRY_W-1:0] head
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] c_full_count = CNT_W'(DEPTH);

   fetch_entry_t     r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (push && !pop)
            r_count <= r_count + 1'b1;
         else if (pop && !push)
            r_count <= r_count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) r_mem[r_wr_ptr] <= wdata;
   end

   assign full  = (r_count == c_full_count);
   assign empty = (r_count == '0);
   assign head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : fetch_unit
// Description : Single-outstanding instruction fetch with redirect and queue.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int DEPTH = FETCH_DEPTH_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_i,
   output logic        pc_stall_o,
   output logic        jump_en_o,
   output logic [31:0] jump_vect_o,
   input  logic        redirect_i,
   input  logic [31:0] redirect_target_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic        dec_valid_o,
   output logic [31:0] dec_instr_o,
   output logic [31:0] dec_pc_o,
   input  logic        dec_ready_i
);

   fetch_state_t              r_state;
   fetch_state_t              w_state_nxt;
   logic [31:0]               r_req_pc;
   logic                      w_req;
   logic                      w_grant;
   logic                      w_push;
   logic                      w_pop;
   logic                      w_full;
   logic                      w_empty;
   logic [FETCH_ENTRY_W-1:0]  w_head;
   fetch_entry_t              w_head_entry;
   fetch_entry_t              w_tail_entry;
   logic                      w_unused_tgt_lsb;

   assign w_req   = (r_state == ST_IDLE) && !reset && !redirect_i && !w_full;
   assign w_grant = w_req && imem_gnt_i;

   always_comb begin
      w_state_nxt = r_state;
      w_push      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_grant) w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (redirect_i)
               w_state_nxt = imem_rvalid_i ? ST_IDLE : ST_DROP;
            else if (imem_rvalid_i) begin
               w_push      = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         ST_DROP: begin
            // The stale response is swallowed whether or not another redirect arrives.
            if (imem_rvalid_i) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_req_pc <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_grant) r_req_pc <= pc_i;
      end
   end

   assign w_tail_entry = '{pc: r_req_pc, instr: imem_rdata_i};
   assign w_pop        = dec_valid_o && dec_ready_i && !redirect_i;

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (w_push),
      .wdata (w_tail_entry),
      .pop   (w_pop),
      .flush (redirect_i),
      .full  (w_full),
      .empty (w_empty),
      .head  (w_head)
   );

   assign w_head_entry     = fetch_entry_t'(w_head);
   assign w_unused_tgt_lsb = ^redirect_target_i[1:0];

   assign imem_req_o  = w_req;
   assign imem_addr_o = pc_i;
   assign pc_stall_o  = !w_grant && !redirect_i;
   assign jump_en_o   = redirect_i;
   assign jump_vect_o = {redirect_target_i[31:2], 2'b00};
   assign dec_valid_o = !reset && !w_empty;
   assign dec_instr_o = w_head_entry.instr;
   assign dec_pc_o    = w_head_entry.pc;

endmodule
`default_nettype wire
